ex_stage: RTL
=============

# ex_stage

Execute stage of the TinyMIPS five-stage pipeline. It consumes the registered ID/EX fields, computes the ALU/shift result selected by `funct`, and forwards memory and write-back controls to the EX/MEM register. It owns the architectural HI/LO registers and an iterative 32-cycle multiply/divide unit, raising `stall_request` to the pipeline controller while a MULT/DIV is in flight.

## Interface
- No parameters; widths come from `bus.v` (`DATA_BUS`=32, `FUNCT_BUS`=6, `SHAMT_BUS`=5, `REG_ADDR_BUS`=5, `ADDR_BUS`=32).
- Timing base: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall_current_stage  in  1  controller holds EX; no HI/LO commit and no muldiv retire while high.
- funct_in  in  6  operation code, MIPS funct encoding; loads and stores arrive as ADDU.
- shamt_in  in  5  immediate shift amount.
- operand_1_in, operand_2_in  in  32 each  rs-side and rt-side operands.
- mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in  in  1 each  memory controls.
- mem_sel_in  in  4  byte enables.
- mem_write_data_in  in  32  store data.
- reg_write_en_in  in  1  write-back enable.
- reg_write_addr_in  in  5  write-back register.
- current_pc_addr_in  in  32  instruction PC.
- result_out  out  32  ALU result or memory address.
- mem_*_out, reg_write_*_out, current_pc_addr_out  out  same widths  combinational pass-through of the matching inputs.
- stall_request  out  1  asserted while the muldiv unit is occupying EX.

## Operation
- Combinational ALU, by funct:
  - ADDU 100001: op1+op2, wrap mod 2^32.
  - SUBU 100011: op1−op2.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise.
  - SLT 101010: signed less-than → 1/0.
  - SLTU 101011: unsigned less-than → 1/0.
  - SLL 000000, SRL 000010, SRA 000011: op2 shifted by shamt_in.
  - SLLV 000100, SRLV 000110, SRAV 000111: op2 shifted by op1[4:0].
  - MFHI 010000: HI. MFLO 010010: LO.
  - Any other funct: result 0.
- MTHI 010001 / MTLO 010011: HI/LO ← op1 on a rising edge where stall_current_stage=0; result_out=0.
- Muldiv FSM, states IDLE, BUSY, DONE:
  - IDLE → BUSY when funct ∈ {MULT 011000, MULTU 011001, DIV 011010, DIVU 011011}. Latch operand magnitudes (abs for signed ops), op type, and sign-fix flags; counter←0.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; counter+1. BUSY → DONE when counter reaches 31.
  - DONE → IDLE when stall_current_stage=0; HI/LO commit on that edge. While stall_current_stage=1, stay in DONE and hold.
- stall_request = (IDLE and muldiv funct) or BUSY; it is 0 in DONE.
- Sign fix:
  - Product negated (64-bit) when operand signs differ.
  - Quotient negated when signs differ.
  - Remainder takes the dividend's sign.
- MULT results: HI=product[63:32], LO=product[31:0]. DIV results: LO=quotient, HI=remainder.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=op1 unmodified. No trap.
- Reset: FSM→IDLE, counter, HI, LO cleared to 0, stall_request=0. Reset mid-BUSY aborts the operation without writing HI/LO.

## Timing
- ALU results, MFHI/MFLO, and pass-through outputs are same-cycle combinational (0 latency).
- A muldiv instruction occupies EX for 34 cycles: 1 IDLE-detect + 32 BUSY (stall_request=1 for 33 cycles) + 1 DONE.
- Under stall, the ID/EX register keeps operands stable, so the FSM reads latched copies only.
- HI/LO are visible to MFHI/MFLO in the cycle after the commit edge, with no forwarding bubble for a back-to-back MFLO.
- A muldiv funct seen in DONE must not restart the FSM; the DONE→IDLE edge advances the pipeline.

## Test plan
- ALU sweep: ADDU 0xFFFFFFFF+1 → 0; SLT 0xFFFFFFFF,1 → 1; SLTU same → 0; SRA 0x80000000 by shamt 4 → 0xF8000000; SRLV op1=36, op2=0x100 → 0x10.
- MULT −3×7, then MFLO/MFHI → stall_request high exactly 33 cycles; LO=0xFFFFFFEB, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by 0 with op1=0x1234 → LO=0xFFFFFFFF, HI=0x1234; completes in 34 cycles.
- stall_current_stage held high for 3 cycles in DONE → FSM holds DONE and HI/LO do not change until the edge after release. MTHI under the same stall → no write.
- rst pulsed at BUSY cycle 10 → next cycle IDLE, stall_request=0, HI=LO=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX input fields and EX/MEM output fields of the execute stage
//
// Purpose: groups the operand, control and result buses around ex_stage.
//   slave  modport : used by ex_stage (consumes ID/EX fields, drives EX/MEM fields)
//   master modport : used by the ID/EX side / test harness (drives ID/EX, observes EX/MEM)
// Signals:
//   funct_in, shamt_in, operand_1_in, operand_2_in   operation and operands
//   mem_*_in, reg_write_*_in, current_pc_addr_in     controls passed through to EX/MEM
//   result_out                                       ALU result / memory address
//   mem_*_out, reg_write_*_out, current_pc_addr_out  pass-through copies

interface ex_stage_if;
    logic [5:0]  funct_in;
    logic [4:0]  shamt_in;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic        mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;

    logic [31:0] result_out;
    logic        mem_read_flag_out;
    logic        mem_write_flag_out;
    logic        mem_sign_ext_flag_out;
    logic [3:0]  mem_sel_out;
    logic [31:0] mem_write_data_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] current_pc_addr_out;

    modport slave (
        input  funct_in, shamt_in, operand_1_in, operand_2_in,
               mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in,
               mem_sel_in, mem_write_data_in, reg_write_en_in,
               reg_write_addr_in, current_pc_addr_in,
        output result_out, mem_read_flag_out, mem_write_flag_out,
               mem_sign_ext_flag_out, mem_sel_out, mem_write_data_out,
               reg_write_en_out, reg_write_addr_out, current_pc_addr_out
    );

    modport master (
        output funct_in, shamt_in, operand_1_in, operand_2_in,
               mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in,
               mem_sel_in, mem_write_data_in, reg_write_en_in,
               reg_write_addr_in, current_pc_addr_in,
        input  result_out, mem_read_flag_out, mem_write_flag_out,
               mem_sign_ext_flag_out, mem_sel_out, mem_write_data_out,
               reg_write_en_out, reg_write_addr_out, current_pc_addr_out
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - TinyMIPS execute stage: ALU, HI/LO and iterative multiply/divide
//
// Purpose: combinational ALU/shifter selected by funct, HI/LO registers written
// by MTHI/MTLO or by a 32-step multiply/divide unit, and pass-through of the
// memory and write-back controls to EX/MEM.
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   stall_current_stage  EX held by the controller; blocks HI/LO writes and muldiv retire
//   stall_request        EX occupied by an in-flight MULT/DIV
//   bus                  ex_stage_if.slave: ID/EX fields in, EX/MEM fields out

module ex_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_current_stage,
    output logic       stall_request,
    ex_stage_if.slave  bus
);

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    // acc_hi/acc_lo form the 64-bit working register: partial product and
    // multiplier for MULT, partial remainder and dividend/quotient for DIV.
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] opb_q, opb_d;          // multiplicand or divisor magnitude
    logic [31:0] op1_raw_q, op1_raw_d;  // untouched dividend for divide-by-zero
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;  // negate product / quotient
    logic        neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic        div_zero_q, div_zero_d;

    logic        is_muldiv;
    logic        op_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_sub;

    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    logic [31:0] op1, op2;

    assign op1 = bus.operand_1_in;
    assign op2 = bus.operand_2_in;

    assign is_muldiv = (bus.funct_in == F_MULT) || (bus.funct_in == F_MULTU) ||
                       (bus.funct_in == F_DIV)  || (bus.funct_in == F_DIVU);
    assign op_signed = (bus.funct_in == F_MULT) || (bus.funct_in == F_DIV);
    assign a_neg     = op_signed & op1[31];
    assign b_neg     = op_signed & op2[31];
    assign a_mag     = a_neg ? (32'd0 - op1) : op1;
    assign b_mag     = b_neg ? (32'd0 - op2) : op2;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the 65-bit {carry, acc_hi, acc_lo} right by one.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);

    // Restoring-divide step: shift the next dividend bit into the remainder
    // and subtract the divisor if it fits. The difference always fits in
    // 32 bits whenever the subtraction is taken.
    assign rem_sh  = {acc_hi_q, acc_lo_q[31]};
    assign div_ge  = (rem_sh >= {1'b0, opb_q});
    assign div_sub = rem_sh[31:0] - opb_q;

    assign prod_fix = neg_res_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    assign quot_fix = neg_res_q ? (32'd0 - acc_lo_q) : acc_lo_q;
    assign rem_fix  = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;

    // Muldiv FSM and HI/LO next state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        acc_hi_d      = acc_hi_q;
        acc_lo_d      = acc_lo_q;
        opb_d         = opb_q;
        op1_raw_d     = op1_raw_q;
        is_div_d      = is_div_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        div_zero_d    = div_zero_q;
        stall_request = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_muldiv) begin
                    stall_request = 1'b1;
                    state_d       = ST_BUSY;
                    cnt_d         = 5'd0;
                    acc_hi_d      = 32'd0;
                    acc_lo_d      = a_mag;
                    opb_d         = b_mag;
                    op1_raw_d     = op1;
                    is_div_d      = (bus.funct_in == F_DIV) || (bus.funct_in == F_DIVU);
                    neg_res_d     = a_neg ^ b_neg;
                    neg_rem_d     = a_neg;
                    div_zero_d    = ((bus.funct_in == F_DIV) || (bus.funct_in == F_DIVU)) &&
                                    (op2 == 32'd0);
                end else if (!stall_current_stage) begin
                    if (bus.funct_in == F_MTHI) hi_d = op1;
                    if (bus.funct_in == F_MTLO) lo_d = op1;
                end
            end
            ST_BUSY: begin
                stall_request = 1'b1;
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_sub : rem_sh[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Retire only when the controller releases EX; the funct still
                // on the bus here is the same muldiv and must not restart.
                if (!stall_current_stage) begin
                    state_d = ST_IDLE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (div_zero_q) begin
                        hi_d = op1_raw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            opb_q      <= 32'd0;
            op1_raw_q  <= 32'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opb_q      <= opb_d;
            op1_raw_q  <= op1_raw_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Combinational ALU / shifter
    always_comb begin
        bus.result_out = 32'd0;
        case (bus.funct_in)
            F_ADDU:  bus.result_out = op1 + op2;
            F_SUBU:  bus.result_out = op1 - op2;
            F_AND:   bus.result_out = op1 & op2;
            F_OR:    bus.result_out = op1 | op2;
            F_XOR:   bus.result_out = op1 ^ op2;
            F_NOR:   bus.result_out = ~(op1 | op2);
            F_SLT:   bus.result_out = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
            F_SLTU:  bus.result_out = (op1 < op2) ? 32'd1 : 32'd0;
            F_SLL:   bus.result_out = op2 << bus.shamt_in;
            F_SRL:   bus.result_out = op2 >> bus.shamt_in;
            F_SRA:   bus.result_out = $unsigned($signed(op2) >>> bus.shamt_in);
            F_SLLV:  bus.result_out = op2 << op1[4:0];
            F_SRLV:  bus.result_out = op2 >> op1[4:0];
            F_SRAV:  bus.result_out = $unsigned($signed(op2) >>> op1[4:0]);
            F_MFHI:  bus.result_out = hi_q;
            F_MFLO:  bus.result_out = lo_q;
            default: bus.result_out = 32'd0;
        endcase
    end

    assign bus.mem_read_flag_out     = bus.mem_read_flag_in;
    assign bus.mem_write_flag_out    = bus.mem_write_flag_in;
    assign bus.mem_sign_ext_flag_out = bus.mem_sign_ext_flag_in;
    assign bus.mem_sel_out           = bus.mem_sel_in;
    assign bus.mem_write_data_out    = bus.mem_write_data_in;
    assign bus.reg_write_en_out      = bus.reg_write_en_in;
    assign bus.reg_write_addr_out    = bus.reg_write_addr_in;
    assign bus.current_pc_addr_out   = bus.current_pc_addr_in;

endmodule
